// File: rtl/fetch_unit.sv
// fetch_unit: ACDC instruction-fetch stage (PC, jump/branch LUT, halt latch, retired counter).
// Rev 1.0. Optional build macro FETCH_LUT_PROG_EN adds a LUT write port.
`default_nettype none

module fetch_unit #(
  parameter int PW = 8,
  parameter int LW = 4,
  parameter logic [(2**LW)*PW-1:0] LUT_INIT = 128'hF0E0D0C0B0A090807060504030201000
) (
  input  logic          CLK,
  input  logic          start,
  input  logic          stall,
  input  logic          halt_req,
  input  logic          jump_en,
  input  logic          branch_en,
  input  logic          cond,
  input  logic [LW-1:0] target_idx,
`ifdef FETCH_LUT_PROG_EN
  input  logic          lut_we,
  input  logic [LW-1:0] lut_waddr,
  input  logic [PW-1:0] lut_wdata,
`endif
  output logic [PW-1:0] PC,
  output logic          halt,
  output logic [15:0]   inst_ct
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [15:0]   inst_ct_q, inst_ct_d;
  logic [PW-1:0] lut_rd;

`ifdef FETCH_LUT_PROG_EN
  logic [(2**LW)*PW-1:0] lut_q, lut_d;

  // Writes land at the edge, so a same-cycle read still sees the old entry.
  always_comb begin
    lut_d = lut_q;
    if (lut_we) begin
      lut_d[PW*lut_waddr +: PW] = lut_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      lut_q <= LUT_INIT;
    end else begin
      lut_q <= lut_d;
    end
  end

  assign lut_rd = lut_q[PW*target_idx +: PW];
`else
  assign lut_rd = LUT_INIT[PW*target_idx +: PW];
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_ct_d = inst_ct_q;
    if (state_q == RUN && !stall) begin
      if (inst_ct_q != 16'hFFFF) begin
        inst_ct_d = inst_ct_q + 16'd1;
      end
      if (halt_req) begin
        state_d = HALTED;
      end else if (jump_en) begin
        pc_d = lut_rd;
      end else if (branch_en && cond) begin
        pc_d = pc_q + lut_rd;
      end else begin
        pc_d = pc_q + {{(PW-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      state_q   <= RUN;
      pc_q      <= '0;
      inst_ct_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_ct_q <= inst_ct_d;
    end
  end

  assign PC      = pc_q;
  assign halt    = (state_q == HALTED);
  assign inst_ct = inst_ct_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
`default_nettype none

module tb_fetch_unit;

  logic       CLK = 1'b0;
  logic       start = 1'b0, stall = 1'b0, halt_req = 1'b0;
  logic       jump_en = 1'b0, branch_en = 1'b0, cond = 1'b0;
  logic [3:0] target_idx = 4'd0;
`ifdef FETCH_LUT_PROG_EN
  logic       lut_we = 1'b0;
  logic [3:0] lut_waddr = 4'd0;
  logic [7:0] lut_wdata = 8'd0;
`endif
  logic [7:0]  PC;
  logic        halt;
  logic [15:0] inst_ct;

  int n_tot = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  fetch_unit dut (
    .CLK        (CLK),
    .start      (start),
    .stall      (stall),
    .halt_req   (halt_req),
    .jump_en    (jump_en),
    .branch_en  (branch_en),
    .cond       (cond),
    .target_idx (target_idx),
`ifdef FETCH_LUT_PROG_EN
    .lut_we     (lut_we),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
`endif
    .PC         (PC),
    .halt       (halt),
    .inst_ct    (inst_ct)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [7:0] pc, input logic h,
                              input logic [15:0] ct);
    chk({tag, ".pc"}, {24'd0, PC}, {24'd0, pc});
    chk({tag, ".halt"}, {31'd0, halt}, {31'd0, h});
    chk({tag, ".ct"}, {16'd0, inst_ct}, {16'd0, ct});
  endtask

  // One clock with the given controls held across the edge, then back to idle.
  task automatic cyc(input logic s, input logic st, input logic h, input logic j,
                     input logic b, input logic c, input logic [3:0] idx);
    start = s; stall = st; halt_req = h; jump_en = j; branch_en = b; cond = c;
    target_idx = idx;
    @(posedge CLK);
    #1;
    start = 1'b0; stall = 1'b0; halt_req = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
    cond = 1'b0; target_idx = 4'd0;
`ifdef FETCH_LUT_PROG_EN
    lut_we = 1'b0;
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 4'd0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 4'd0);
    cyc(1, 0, 0, 0, 0, 0, 4'd0);
  endtask

  initial begin
    @(negedge CLK);
    do_reset();
    expect_state("reset", 8'h00, 1'b0, 16'd0);
    idle(1); expect_state("inc1", 8'h01, 1'b0, 16'd1);
    idle(1); expect_state("inc2", 8'h02, 1'b0, 16'd2);
    idle(1); expect_state("inc3", 8'h03, 1'b0, 16'd3);

    cyc(0, 0, 0, 1, 0, 0, 4'd3); expect_state("jump3", 8'h30, 1'b0, 16'd4);
    cyc(0, 0, 0, 1, 1, 1, 4'd3); expect_state("jump_over_branch", 8'h30, 1'b0, 16'd5);

    do_reset(); idle(5); expect_state("at5", 8'h05, 1'b0, 16'd5);
    cyc(0, 0, 0, 0, 1, 1, 4'd15); expect_state("br_taken", 8'hF5, 1'b0, 16'd6);
    do_reset(); idle(5);
    cyc(0, 0, 0, 0, 1, 0, 4'd15); expect_state("br_not_taken", 8'h06, 1'b0, 16'd6);

    cyc(0, 0, 0, 1, 0, 0, 4'd15); expect_state("jumpF0", 8'hF0, 1'b0, 16'd7);
    idle(15); expect_state("atFF", 8'hFF, 1'b0, 16'd22);
    idle(1);  expect_state("wrap", 8'h00, 1'b0, 16'd23);

    cyc(0, 0, 0, 1, 0, 0, 4'd1); expect_state("jump10", 8'h10, 1'b0, 16'd24);
    cyc(0, 1, 0, 0, 0, 0, 4'd0); expect_state("stall1", 8'h10, 1'b0, 16'd24);
    cyc(0, 1, 0, 1, 0, 0, 4'd3); expect_state("stall2_jump", 8'h10, 1'b0, 16'd24);
    cyc(0, 1, 0, 0, 1, 1, 4'd1); expect_state("stall3_branch", 8'h10, 1'b0, 16'd24);
    cyc(0, 1, 0, 0, 0, 0, 4'd0); expect_state("stall4", 8'h10, 1'b0, 16'd24);
    idle(1); expect_state("stall_release", 8'h11, 1'b0, 16'd25);
    cyc(0, 1, 1, 0, 0, 0, 4'd0); expect_state("stall_over_halt", 8'h11, 1'b0, 16'd25);

    cyc(0, 0, 0, 1, 0, 0, 4'd2); expect_state("jump20", 8'h20, 1'b0, 16'd26);
    cyc(0, 0, 1, 1, 0, 0, 4'd3); expect_state("halt", 8'h20, 1'b1, 16'd27);
    cyc(0, 0, 0, 0, 1, 1, 4'd15); expect_state("halted_branch", 8'h20, 1'b1, 16'd27);
    cyc(0, 0, 1, 1, 0, 0, 4'd1); expect_state("halted_jump", 8'h20, 1'b1, 16'd27);
    idle(2); expect_state("halted_idle", 8'h20, 1'b1, 16'd27);
    cyc(1, 0, 0, 0, 0, 0, 4'd0); expect_state("start_from_halt", 8'h00, 1'b0, 16'd0);

    idle(1); expect_state("post_start", 8'h01, 1'b0, 16'd1);
    cyc(1, 1, 0, 1, 0, 0, 4'd3); expect_state("start_during_stall", 8'h00, 1'b0, 16'd0);

`ifdef FETCH_LUT_PROG_EN
    lut_we = 1'b1; lut_waddr = 4'd2; lut_wdata = 8'h7A;
    cyc(0, 0, 0, 1, 0, 0, 4'd2); expect_state("wr_jump_old", 8'h20, 1'b0, 16'd1);
    cyc(0, 0, 0, 1, 0, 0, 4'd2); expect_state("jump_new", 8'h7A, 1'b0, 16'd2);
    lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 8'h44;
    cyc(0, 1, 0, 0, 0, 0, 4'd0); expect_state("wr_stalled", 8'h7A, 1'b0, 16'd2);
    cyc(0, 0, 0, 1, 0, 0, 4'd3); expect_state("jump_stall_wr", 8'h44, 1'b0, 16'd3);
    lut_we = 1'b1; lut_waddr = 4'd2; lut_wdata = 8'h99;
    cyc(1, 0, 0, 0, 0, 0, 4'd0); expect_state("start_vs_we", 8'h00, 1'b0, 16'd0);
    cyc(0, 0, 0, 1, 0, 0, 4'd2); expect_state("lut_reloaded", 8'h20, 1'b0, 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
